spi_dac_frame_receiver: RTL and testbench



---
 rtl/spi_dac_frame_receiver.sv | 169 ++++++++++++++++
 tb/tb_spi_dac_frame_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_frame_receiver.sv
// SPI slave monitor for the three-wire DAC link (SCLK, SYNC_n, DIN).
// All pins are oversampled on the 50 MHz system clock; SCLK is treated as data.
// Each accepted 16-bit frame yields a 12-bit sample plus two power-down bits.
module spi_dac_frame_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_BITS  = 16
) (
  input  logic                  clock_50Mhz,
  input  logic                  reset_n,
  input  logic                  input_SPI_SCLK,
  input  logic                  input_SPI_SYNC_n,
  input  logic                  input_SPI_DIN,
  output logic [DATA_BITS-1:0]  outputSample,
  output logic [1:0]            outputPowerDown,
  output logic                  sampleValid,
  output logic                  frameError,
  output logic [COUNT_BITS-1:0] frameCount,
  output logic                  isReceiving
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    WAIT_END = 2'd3
  } state_e;

  // Synchronizer chains and the edge-detect stage behind them
  logic [SYNC_STAGES-1:0] sclk_sync_q, sync_sync_q, din_sync_q;
  logic                   sclk_d1_q, sync_d1_q, din_d1_q;
  logic                   sclk_s, sync_s;
  logic                   sclk_fall_s, sync_fall_s, sync_rise_s;

  // FSM and datapath state
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;
  logic [1:0]             pd_q, pd_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [COUNT_BITS-1:0]  count_q, count_d;
  logic                   recv_q, recv_d;

  // Resynchronise the pins; reset values match the idle line levels
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b1}};
      sync_sync_q <= {SYNC_STAGES{1'b1}};
      din_sync_q  <= {SYNC_STAGES{1'b0}};
      sclk_d1_q   <= 1'b1;
      sync_d1_q   <= 1'b1;
      din_d1_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], input_SPI_SCLK};
      sync_sync_q <= {sync_sync_q[SYNC_STAGES-2:0], input_SPI_SYNC_n};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], input_SPI_DIN};
      sclk_d1_q   <= sclk_sync_q[SYNC_STAGES-1];
      sync_d1_q   <= sync_sync_q[SYNC_STAGES-1];
      din_d1_q    <= din_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign sync_s      = sync_sync_q[SYNC_STAGES-1];
  assign sclk_fall_s = sclk_d1_q & ~sclk_s;
  assign sync_fall_s = sync_d1_q & ~sync_s;
  assign sync_rise_s = ~sync_d1_q & sync_s;

  // Frame FSM: next state, shift/count update and output pulse generation
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    pd_d      = pd_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    count_d   = count_q;
    recv_d    = recv_q;
    case (state_q)
      IDLE: begin
        if (sync_fall_s) begin
          bit_cnt_d = {CNT_W{1'b0}};
          shift_d   = {FRAME_BITS{1'b0}};
          recv_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sclk_fall_s) begin
          shift_d   = (shift_q << 1) | FRAME_BITS'(din_d1_q);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          shift_d   = shift_q;
        end
        // A frame completing on the same cycle as SYNC_n rising is accepted
        if (sclk_fall_s && (bit_cnt_q == CNT_W'(FRAME_BITS - 1))) begin
          state_d = DONE;
        end else if (sync_rise_s) begin
          err_d   = 1'b1;
          recv_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        sample_d = shift_q[DATA_BITS-1:0];
        pd_d     = shift_q[DATA_BITS+1:DATA_BITS];
        valid_d  = 1'b1;
        count_d  = count_q + COUNT_BITS'(1);
        state_d  = WAIT_END;
      end
      WAIT_END: begin
        // Level test covers both a rising edge and SYNC_n already high
        if (sync_s) begin
          recv_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_END;
        end
      end
      default: begin
        recv_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= {CNT_W{1'b0}};
      shift_q   <= {FRAME_BITS{1'b0}};
      sample_q  <= {DATA_BITS{1'b0}};
      pd_q      <= 2'b00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= {COUNT_BITS{1'b0}};
      recv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      pd_q      <= pd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      count_q   <= count_d;
      recv_q    <= recv_d;
    end
  end

  assign outputSample    = sample_q;
  assign outputPowerDown = pd_q;
  assign sampleValid     = valid_q;
  assign frameError      = err_q;
  assign frameCount      = count_q;
  assign isReceiving     = recv_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Bench for spi_dac_frame_receiver: directed vector table, randomized frames
// against a frame-level reference model, and hand-written corner sequences.
module tb_spi_dac_frame_receiver;

  localparam int LATENCY = 4; // SYNC_STAGES + 2

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, sync_n, din;
  logic [11:0] sample;
  logic [1:0]  pd;
  logic        valid, ferr, recv;
  logic [15:0] fcount;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int fall16_cyc = 0;

  // Reference model state (frame-level view of the link)
  logic [11:0] m_sample;
  logic [1:0]  m_pd;
  logic [15:0] m_count;

  spi_dac_frame_receiver dut (
    .clock_50Mhz     (clk),
    .reset_n         (rst_n),
    .input_SPI_SCLK  (sclk),
    .input_SPI_SYNC_n(sync_n),
    .input_SPI_DIN   (din),
    .outputSample    (sample),
    .outputPowerDown (pd),
    .sampleValid     (valid),
    .frameError      (ferr),
    .frameCount      (fcount),
    .isReceiving     (recv)
  );

  always #10 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (ferr) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [31:0] stream;
    int          nedges;
    bit          sync_last;
    logic [11:0] exp_sample;
    logic [1:0]  exp_pd;
    logic [15:0] exp_count;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b; tick(2);
    sclk = 1'b0; tick(4);
    sclk = 1'b1; tick(2);
  endtask

  // Drive one SYNC_n window carrying nedges bits taken MSB-first from stream
  task automatic send_frame(input logic [31:0] stream, input int nedges, input bit sync_last);
    sync_n = 1'b0; tick(4);
    for (int k = 0; k < nedges; k++) begin
      din = stream[31-k]; tick(2);
      sclk = 1'b0;
      if (k == 15) fall16_cyc = cyc;
      if (sync_last && k == nedges - 1) sync_n = 1'b1;
      tick(4);
      sclk = 1'b1; tick(2);
    end
    tick(2);
    sync_n = 1'b1; tick(6);
  endtask

  // Frame-level model: 16+ clock edges is a frame, fewer is an abort
  task automatic model_frame(input logic [31:0] stream, input int nedges,
                             output int ev, output int ee);
    int word;
    word = int'(stream >> 16);
    if (nedges >= 16) begin
      m_sample = 12'(word % 4096);
      m_pd     = 2'((word / 4096) % 4);
      m_count  = 16'((int'(m_count) + 1) % 65536);
      ev = 1; ee = 0;
    end else begin
      ev = 0; ee = 1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] stream, input int nedges,
                           input bit sync_last, input logic [11:0] es, input logic [1:0] ep,
                           input logic [15:0] ec, input int ev, input int ee);
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(stream, nedges, sync_last);
    check({tag, " valid pulses"}, valid_cnt - v0, ev);
    check({tag, " error pulses"}, err_cnt - e0, ee);
    check({tag, " sample"}, {20'd0, sample}, {20'd0, es});
    check({tag, " powerdown"}, {30'd0, pd}, {30'd0, ep});
    check({tag, " count"}, {16'd0, fcount}, {16'd0, ec});
    check({tag, " receiving"}, {31'd0, recv}, 32'd0);
    if (ev == 1) check({tag, " latency"}, last_valid_cyc - fall16_cyc, LATENCY);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sample"}, {20'd0, sample}, 32'd0);
    check({tag, " powerdown"}, {30'd0, pd}, 32'd0);
    check({tag, " valid"}, {31'd0, valid}, 32'd0);
    check({tag, " error"}, {31'd0, ferr}, 32'd0);
    check({tag, " count"}, {16'd0, fcount}, 32'd0);
    check({tag, " receiving"}, {31'd0, recv}, 32'd0);
  endtask

  initial begin
    int ev, ee, n, e0;
    logic [31:0] s;

    vecs[0] = '{{16'h0ABC, 16'h0000}, 16, 1'b0, 12'hABC, 2'd0, 16'd1, 1, 0};
    vecs[1] = '{{16'h3FFF, 16'h0000}, 16, 1'b0, 12'hFFF, 2'd3, 16'd2, 1, 0};
    vecs[2] = '{{16'h0001, 16'h0000}, 16, 1'b0, 12'h001, 2'd0, 16'd3, 1, 0};
    vecs[3] = '{{16'h0555, 16'h0000},  9, 1'b0, 12'h001, 2'd0, 16'd3, 0, 1};
    vecs[4] = '{{16'h0123, 16'h0000}, 16, 1'b0, 12'h123, 2'd0, 16'd4, 1, 0};
    vecs[5] = '{{16'h0F0F, 16'hF000}, 20, 1'b0, 12'hF0F, 2'd0, 16'd5, 1, 0};
    vecs[6] = '{{16'h0000, 16'h0000},  0, 1'b0, 12'hF0F, 2'd0, 16'd5, 0, 1};
    vecs[7] = '{{16'h2456, 16'h0000}, 16, 1'b1, 12'h456, 2'd2, 16'd6, 1, 0};

    rst_n = 1'b0; sclk = 1'b1; sync_n = 1'b1; din = 1'b0;
    m_sample = 12'd0; m_pd = 2'd0; m_count = 16'd0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1; tick(4);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      model_frame(vecs[i].stream, vecs[i].nedges, ev, ee);
      run_frame($sformatf("vec%0d", i), vecs[i].stream, vecs[i].nedges, vecs[i].sync_last,
                vecs[i].exp_sample, vecs[i].exp_pd, vecs[i].exp_count,
                vecs[i].exp_valid, vecs[i].exp_err);
    end

    // Randomized frames against the model
    for (int i = 0; i < 30; i++) begin
      s = $urandom;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 20));
      model_frame(s, n, ev, ee);
      run_frame($sformatf("rnd%0d", i), s, n, 1'b0, m_sample, m_pd, m_count, ev, ee);
    end

    // Frame counter wrap
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    tick(1);
    release dut.count_q;
    tick(1);
    check("wrap preset", {16'd0, fcount}, 32'h0000FFFF);
    m_count = 16'hFFFF;
    s = {16'h1A5C, 16'h0000};
    model_frame(s, 16, ev, ee);
    run_frame("wrap", s, 16, 1'b0, m_sample, m_pd, m_count, ev, ee);
    check("wrap count zero", {16'd0, fcount}, 32'd0);

    // Reset in the middle of a frame
    sync_n = 1'b0; tick(4);
    for (int k = 0; k < 8; k++) send_bit(1'($urandom_range(0, 1)));
    check("midframe receiving", {31'd0, recv}, 32'd1);
    e0 = err_cnt;
    rst_n = 1'b0; sync_n = 1'b1; sclk = 1'b1; din = 1'b0;
    tick(2);
    check_reset_outputs("midreset");
    rst_n = 1'b1; tick(6);
    check("midreset no error", err_cnt - e0, 0);
    m_sample = 12'd0; m_pd = 2'd0; m_count = 16'd0;
    run_frame("after reset", {16'h0777, 16'h0000}, 16, 1'b0, 12'h777, 2'd0, 16'd1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
